nrs_gold_scheduler: RTL and testbench

Sequences the NRS Gold-sequence generator over one radio frame and fills the ping-pong c_n buffer that feeds the NRS estimators. On each `new_frame` pulse it walks slots 0..19, skipping slots 10 and 11, and symbols l=5,6. For each symbol it computes c_init, seeds the external x1/x2 LFSR pair, runs the 1600-shift warm-up, then captures 4 c_n bits into the buffer. Completed subframes (16 bits each) are offered to the consumer with a valid/ack handshake.

---
 rtl/nrs_gold_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_nrs_gold_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrs_gold_scheduler.sv
// Purpose: per-frame sequencer for the NRS Gold generator; seeds x1/x2 for each NRS symbol,
//          runs the warm-up, and writes 4 c_n bits per symbol into a ping-pong subframe buffer.
// Latency: new_frame -> seed_load 2 cycles, -> first wr_en 1603 cycles; 1607 cycles per symbol unstalled.
// Backpressure: a completed bank is offered via sf_valid/sf_ack; the FSM parks in HOLD before
//          seeding while its target bank is still full.
// Ports:   clk/rst (sync, active-high); new_frame + N_cell_ID start a frame; c_bit from the generator;
//          seed_load/cinit/shift_en drive the generator; wr_* is the buffer write port;
//          sf_valid/sf_bank/sf_num/sf_ack is the subframe hand-off; busy and frame_done report progress.
module nrs_gold_scheduler #(
    parameter int NUM_SHIFTS   = 1600,
    parameter int BITS_PER_SYM = 4,
    parameter int WIDTH_B      = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_frame,
    input  logic [WIDTH_B-1:0] N_cell_ID,
    input  logic               c_bit,
    input  logic               sf_ack,
    output logic               seed_load,
    output logic [27:0]        cinit,
    output logic               shift_en,
    output logic               wr_en,
    output logic               wr_bank,
    output logic [3:0]         wr_addr,
    output logic               wr_data,
    output logic               sf_valid,
    output logic               sf_bank,
    output logic [3:0]         sf_num,
    output logic               busy,
    output logic               frame_done
);

    localparam int CNT_W = $clog2(NUM_SHIFTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CINIT,
        S_HOLD,
        S_SEED,
        S_WARM,
        S_OUT,
        S_NEXT
    } state_t;

    state_t             state;
    logic [WIDTH_B-1:0] cell_id;
    logic [4:0]         ns;
    logic               l_hi;        // 0 -> l=5, 1 -> l=6
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         bank_full;
    logic               q_vld;       // one completed bank waiting behind the current offer
    logic               q_bank;
    logic [3:0]         q_num;

    // c_init = (7*(ns+1)+l+1)*(2N+1)*1024 + 2N+1; first factor is at most 147, so 8 bits.
    logic [7:0]       fac_a;
    logic [WIDTH_B:0] fac_b;
    logic [27:0]      prod;
    logic [27:0]      cinit_calc;

    always_comb begin
        fac_a      = 8'(ns) * 8'd7 + 8'd13 + {7'd0, l_hi};
        fac_b      = {cell_id, 1'b1};
        prod       = 28'(fac_a) * 28'(fac_b);
        cinit_calc = (prod << 10) + 28'(fac_b);
    end

    // The generator output is consumed directly while writing; gated so it reads 0 otherwise.
    assign wr_data = wr_en & c_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cell_id    <= '0;
            ns         <= '0;
            l_hi       <= 1'b0;
            cnt        <= '0;
            bank_full  <= 2'b00;
            q_vld      <= 1'b0;
            q_bank     <= 1'b0;
            q_num      <= 4'd0;
            seed_load  <= 1'b0;
            cinit      <= 28'd0;
            shift_en   <= 1'b0;
            wr_en      <= 1'b0;
            wr_bank    <= 1'b0;
            wr_addr    <= 4'd0;
            sf_valid   <= 1'b0;
            sf_bank    <= 1'b0;
            sf_num     <= 4'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            seed_load  <= 1'b0;
            frame_done <= 1'b0;

            // Offer handshake: an accepted ack frees the offered bank; a queued bank is
            // promoted only once the line has been low for a cycle.
            if (sf_valid && sf_ack) begin
                bank_full[sf_bank] <= 1'b0;
                sf_valid           <= 1'b0;
            end else if (!sf_valid && q_vld) begin
                sf_valid <= 1'b1;
                sf_bank  <= q_bank;
                sf_num   <= q_num;
                q_vld    <= 1'b0;
            end

            unique case (state)
                S_IDLE: ;
                S_CINIT: begin
                    cinit <= cinit_calc;
                    if (!bank_full[wr_bank]) begin
                        state     <= S_SEED;
                        seed_load <= 1'b1;
                    end else begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!bank_full[wr_bank]) begin
                        state     <= S_SEED;
                        seed_load <= 1'b1;
                    end
                end
                S_SEED: begin
                    state    <= S_WARM;
                    shift_en <= 1'b1;
                    cnt      <= '0;
                end
                S_WARM: begin
                    if (cnt == CNT_W'(NUM_SHIFTS - 1)) begin
                        state   <= S_OUT;
                        wr_en   <= 1'b1;
                        wr_addr <= {ns[0], l_hi, 2'b00};
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (cnt == CNT_W'(BITS_PER_SYM - 1)) begin
                        state    <= S_NEXT;
                        wr_en    <= 1'b0;
                        shift_en <= 1'b0;
                        // Last write of an odd slot closes the subframe held in wr_bank.
                        if (ns[0] && l_hi) begin
                            bank_full[wr_bank] <= 1'b1;
                            wr_bank            <= ~wr_bank;
                            if (!sf_valid && !q_vld) begin
                                sf_valid <= 1'b1;
                                sf_bank  <= wr_bank;
                                sf_num   <= ns[4:1];
                            end else begin
                                q_vld  <= 1'b1;
                                q_bank <= wr_bank;
                                q_num  <= ns[4:1];
                            end
                        end
                        if (ns == 5'd19 && l_hi) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end else begin
                        cnt     <= cnt + 1'b1;
                        wr_addr <= wr_addr + 4'd1;
                    end
                end
                S_NEXT: begin
                    if (!l_hi) begin
                        l_hi  <= 1'b1;
                        state <= S_CINIT;
                    end else if (ns == 5'd19) begin
                        state <= S_IDLE;
                    end else begin
                        l_hi  <= 1'b0;
                        ns    <= (ns == 5'd9) ? 5'd12 : ns + 5'd1;
                        state <= S_CINIT;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A new frame overrides everything above. Mid-frame it also abandons the old
            // frame's banks and offers; between frames, offers still pending are kept.
            if (new_frame) begin
                cell_id    <= N_cell_ID;
                ns         <= 5'd0;
                l_hi       <= 1'b0;
                cnt        <= '0;
                busy       <= 1'b1;
                state      <= S_CINIT;
                seed_load  <= 1'b0;
                shift_en   <= 1'b0;
                wr_en      <= 1'b0;
                wr_addr    <= 4'd0;
                frame_done <= 1'b0;
                if (busy) begin
                    bank_full <= 2'b00;
                    sf_valid  <= 1'b0;
                    q_vld     <= 1'b0;
                    wr_bank   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_nrs_gold_scheduler.sv
// Purpose: self-checking bench for nrs_gold_scheduler with a behavioural frame/Gold reference.
// Latency: checks seed at T+2, first write at T+1603, offer one cycle after subframe end.
// Backpressure: exercises random acks, held-off acks (HOLD), mid-frame restart and reset.
module tb_nrs_gold_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_frame;
    logic [8:0]  n_cell;
    logic        c_bit;
    logic        sf_ack;
    logic        seed_load;
    logic [27:0] cinit;
    logic        shift_en;
    logic        wr_en;
    logic        wr_bank;
    logic [3:0]  wr_addr;
    logic        wr_data;
    logic        sf_valid;
    logic        sf_bank;
    logic [3:0]  sf_num;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    nrs_gold_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .new_frame  (new_frame),
        .N_cell_ID  (n_cell),
        .c_bit      (c_bit),
        .sf_ack     (sf_ack),
        .seed_load  (seed_load),
        .cinit      (cinit),
        .shift_en   (shift_en),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sf_valid   (sf_valid),
        .sf_bank    (sf_bank),
        .sf_num     (sf_num),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // External x1/x2 generator driven by the DUT's seed/shift controls.
    logic [30:0] g1, g2;
    always @(posedge clk) begin
        if (rst) begin
            g1 <= 31'd0;
            g2 <= 31'd0;
        end else if (seed_load) begin
            g1 <= 31'd1;
            g2 <= {3'b000, cinit};
        end else if (shift_en) begin
            g1 <= {g1[0] ^ g1[3], g1[30:1]};
            g2 <= {g2[3] ^ g2[2] ^ g2[1] ^ g2[0], g2[30:1]};
        end
    end
    assign c_bit = g1[0] ^ g2[0];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int slot_of(input int k);  // k-th NRS slot of the frame, 10/11 skipped
        return (k < 10) ? k : k + 2;
    endfunction

    function automatic logic [27:0] ref_cinit(input int ns, input int l, input int n);
        int a;
        int b;
        a = 7 * (ns + 1) + l + 1;
        b = 2 * n + 1;
        return 28'(a * b * 1024 + b);
    endfunction

    function automatic logic [3:0] ref_bits(input logic [27:0] ci);
        logic [30:0] x1, x2;
        logic [3:0]  r;
        x1 = 31'd1;
        x2 = {3'b000, ci};
        r  = 4'd0;
        for (int i = 0; i < 1604; i++) begin
            if (i >= 1600) r[i-1600] = x1[0] ^ x2[0];
            x1 = {x1[0] ^ x1[3], x1[30:1]};
            x2 = {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
        end
        return r;
    endfunction

    bit         mon_on = 0;
    bit         chk_t = 0;
    bit         chk_rise = 0;
    int         m_n = 0;
    int         sym_i = 0;
    int         bit_i = 0;
    int         offer_i = 0;
    int         frame_t = 0;
    int         sf_done_cyc = 0;
    int         last_wr_cyc = 0;
    int         done_cnt = 0;
    int         wr_cnt = 0;
    int         seed_cnt = 0;
    logic [3:0] exp_bits = 4'd0;
    logic       sfv_prev = 1'b0;

    always @(negedge clk) begin : mon
        int slot;
        int lv;
        int exp_sf;
        if (mon_on) begin
            slot = slot_of(sym_i / 2);
            lv   = 5 + (sym_i % 2);
            if (seed_load) begin
                seed_cnt++;
                if (sym_i >= 36) chk("seed_past_end", sym_i, 35);
                else begin
                    chk("cinit", cinit, ref_cinit(slot, lv, m_n));
                    exp_bits = ref_bits(ref_cinit(slot, lv, m_n));
                    chk("seed_bitpos", bit_i, 0);
                    if (sym_i == 0 && chk_t) chk("seed_lat", cyc - frame_t, 2);
                end
            end
            if (wr_en) begin
                wr_cnt++;
                if (sym_i >= 36) chk("wr_past_end", sym_i, 35);
                else begin
                    chk("wr_addr", wr_addr, (slot % 2) * 8 + (lv - 5) * 4 + bit_i);
                    chk("wr_bank", wr_bank, (sym_i / 4) % 2);
                    chk("wr_data", wr_data, exp_bits[bit_i]);
                    if (sym_i == 0 && bit_i == 0 && chk_t) chk("wr_lat", cyc - frame_t, 1603);
                    bit_i++;
                    if (bit_i == 4) begin
                        bit_i = 0;
                        sym_i++;
                        if (sym_i % 4 == 0) sf_done_cyc = cyc;
                        if (sym_i == 36) last_wr_cyc = cyc;
                    end
                end
            end
            if (sf_valid && !sfv_prev) begin
                exp_sf = (offer_i < 5) ? offer_i : offer_i + 1;
                chk("sf_num", sf_num, exp_sf);
                chk("sf_bank", sf_bank, offer_i % 2);
                if (chk_rise) chk("sf_rise", cyc - sf_done_cyc, 1);
                offer_i++;
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_lat", cyc - last_wr_cyc, 1);
                chk("done_busy", busy, 0);
            end
        end
        sfv_prev = sf_valid;
    end

    // ---------------- consumer ----------------
    bit ack_auto = 0;
    bit ack_man = 0;
    initial begin
        sf_ack = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            // Random acks also land while sf_valid is low, where they must be ignored.
            sf_ack = ack_auto ? ($urandom_range(0, 2) == 0) : ack_man;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_frame(input int n);
        new_frame = 1'b1;
        n_cell    = 9'(n);
        m_n       = n;
        sym_i     = 0;
        bit_i     = 0;
        offer_i   = 0;
        frame_t   = cyc;
        step();
        new_frame = 1'b0;
    endtask

    task automatic wait_sym(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (sym_i >= target) break;
            step();
        end
        chk(tag, sym_i, target);
    endtask

    task automatic pulse_ack();
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
    endtask

    initial begin : main
        int w0;
        int s0;
        logic [3:0] acc;
        rst       = 1'b1;
        new_frame = 1'b0;
        n_cell    = 9'd0;
        repeat (3) step();
        chk("rst_cinit", cinit, 0);
        chk("rst_outs", {seed_load, shift_en, wr_en, wr_bank, wr_addr, wr_data,
                         sf_valid, sf_bank, sf_num, busy, frame_done}, 0);
        rst = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // Full frame, random acks, bit-exact check against the Gold model.
        ack_auto = 1; chk_t = 1; chk_rise = 1; mon_on = 1;
        start_frame(503);
        chk("busy_set", busy, 1);
        for (int i = 0; i < 60000; i++) begin
            if (done_cnt != 0) break;
            step();
        end
        chk("frame_done_seen", done_cnt, 1);
        repeat (40) step();
        chk("frame_syms", sym_i, 36);
        chk("frame_writes", wr_cnt, 144);
        chk("frame_offers", offer_i, 9);
        chk("done_once", done_cnt, 1);
        chk("busy_end", busy, 0);
        chk("last_ack", sf_valid, 0);

        // Backpressure: no acks until the FSM stalls in front of subframe 2.
        mon_on = 0; ack_auto = 0; chk_rise = 0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        wr_cnt = 0; seed_cnt = 0; done_cnt = 0;
        mon_on = 1;
        start_frame(0);
        wait_sym(8, 8 * 1607 + 50, "sf1_done");
        w0 = wr_cnt;
        s0 = seed_cnt;
        repeat ($urandom_range(500, 3000)) step();
        chk("hold_no_wr", wr_cnt - w0, 0);
        chk("hold_no_seed", seed_cnt - s0, 0);
        chk("hold_shift", shift_en, 0);
        chk("hold_busy", busy, 1);
        chk("hold_offer", {sf_valid, sf_bank, sf_num}, 6'b100000);
        pulse_ack();
        wait_sym(12, 4 * 1607 + 100, "sf2_done");
        repeat (50) step();
        pulse_ack();
        for (int i = 0; i < 200; i++) begin
            if (seed_cnt >= 13) break;
            step();
        end
        chk("sf3_seed", seed_cnt, 13);
        repeat ($urandom_range(10, 1500)) step();
        chk("pre_abort_warm", {shift_en, wr_en}, 2'b10);
        chk("pre_abort_sfv", sf_valid, 1);

        // Restart mid-WARM with a new cell ID.
        w0 = wr_cnt;
        start_frame(1);
        step();
        chk("abort_sfv_drop", sf_valid, 0);
        for (int i = 0; i < 1700; i++) begin
            if (wr_cnt - w0 >= 2) break;
            step();
        end
        chk("abort_wr_cnt", wr_cnt - w0, 2);
        chk("mid_out", wr_en, 1);

        // Reset together with new_frame in the middle of OUT.
        mon_on    = 0;
        rst       = 1'b1;
        new_frame = 1'b1;
        n_cell    = 9'd77;
        step();
        chk("rst2_cinit", cinit, 0);
        chk("rst2_outs", {seed_load, shift_en, wr_en, wr_bank, wr_addr, wr_data,
                          sf_valid, sf_bank, sf_num, busy, frame_done}, 0);
        rst       = 1'b0;
        new_frame = 1'b0;
        acc = 4'd0;
        repeat (20) begin
            step();
            acc = acc | {busy, seed_load, shift_en, wr_en};
        end
        chk("idle_after_rst", acc, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
